// File: rtl/cpu_cmd_fifo_if.sv
// CPU window and MCU pop-side signals of the CPU-to-MCU command FIFO.
// master = bus/MCU side driving the FIFO, slave = the FIFO itself.
interface cpu_cmd_fifo_if;
  logic        cpu_ce;
  logic        cpu_addr;
  logic        cpu_we_hi;
  logic        cpu_we_lo;
  logic [15:0] cpu_dato;
  logic [15:0] cpu_dati;
  logic        mcu_rd;
  logic        mcu_clr;
  logic [31:0] mcu_dati;
  logic        mcu_irq;

  modport master (
    output cpu_ce, cpu_addr, cpu_we_hi, cpu_we_lo, cpu_dato, mcu_rd, mcu_clr,
    input  cpu_dati, mcu_dati, mcu_irq
  );

  modport slave (
    input  cpu_ce, cpu_addr, cpu_we_hi, cpu_we_lo, cpu_dato, mcu_rd, mcu_clr,
    output cpu_dati, mcu_dati, mcu_irq
  );
endinterface

// File: rtl/cpu_cmd_fifo.sv
// CPU-to-MCU command FIFO: CPU writes into a two-register window, the MCU pops.
// Optional MCU interrupt enabled by defining CPU_CMD_FIFO_IRQ_EN.
module cpu_cmd_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned IRQ_LVL = 1
) (
  input  logic         clk,
  input  logic         rst,
  cpu_cmd_fifo_if.slave bus
);

  localparam logic [AW:0] FullCnt  = (AW+1)'(DEPTH);
  localparam logic        IrqLvlOk = (IRQ_LVL >= 1) && (IRQ_LVL <= DEPTH);

  logic [2:0]    hist_q, hist_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   dati_q, dati_d;
  logic [15:0]   mem_q [DEPTH];

  logic          act, commit, push, pop;
  logic [15:0]   wdata, head_d;

  always_comb begin
    act   = bus.cpu_ce & ~bus.cpu_addr & (bus.cpu_we_hi | bus.cpu_we_lo);
    hist_d = {hist_q[1:0], act};
    // Rising edge seen on two consecutive samples: one commit per write
    commit = (hist_q == 3'b011) & ~bus.mcu_clr;
    wdata  = {bus.cpu_we_hi ? bus.cpu_dato[15:8] : 8'h00,
              bus.cpu_we_lo ? bus.cpu_dato[7:0]  : 8'h00};
    pop    = bus.mcu_rd & (count_q != '0) & ~bus.mcu_clr;
    push   = commit & ((count_q != FullCnt) | pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.mcu_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (commit & ~push) ovf_d = 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end

    // Registered view reflects post-edge state; a word being written this
    // cycle is not in mem_q yet, so forward it when it becomes the head.
    if (count_d == '0)
      head_d = '0;
    else if (push && (wr_ptr_q == rd_ptr_d))
      head_d = wdata;
    else
      head_d = mem_q[rd_ptr_d];

    dati_d = {ovf_d, count_d == FullCnt, count_d == '0, 5'b0, 8'(count_d), head_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      dati_q   <= 32'h2000_0000;
    end else begin
      hist_q   <= hist_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      dati_q   <= dati_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign bus.mcu_dati = dati_q;
  assign bus.cpu_dati = bus.cpu_addr ? dati_q[31:16] : '0;

`ifdef CPU_CMD_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = IrqLvlOk & ((count_d >= (AW+1)'(IRQ_LVL)) | ovf_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign bus.mcu_irq = irq_q;
`else
  // IRQ_LVL only range-checked here; the interrupt is disabled
  assign bus.mcu_irq = IrqLvlOk & 1'b0;
`endif

endmodule
